// File: rtl/fibonacci_mc_if.sv
// fibonacci_mc_if: valid/ready data bus shared by the Fibonacci engine and memory.
//   addr   byte address            size   log2(bytes per word)
//   valid  request pending         write  1 = write, 0 = read
//   wdata  write data              rdata  read data, valid when ready=1
//   ready  transfer completes this cycle
interface fibonacci_mc_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic [AW-1:0]   addr;
  logic [2:0]      size;
  logic            valid;
  logic            write;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ready;
  modport master (output addr, size, valid, write, wdata, input rdata, ready);
  modport slave  (input addr, size, valid, write, wdata, output rdata, ready);
endinterface

// File: rtl/fibonacci_mc.sv
// fibonacci_mc: multi-context Fibonacci step engine, bus master on fibonacci_mc_if.
//   clk, rstb      clock (rising edge), asynchronous active-low reset
//   start          begin a run, accepted only while idle=1
//   base, ctx_mask byte address of context 0 and contexts to process, latched on start
//   idle, done     engine idle / one-cycle end-of-run pulse
//   cur_ctx        context being processed
//   ovf            sticky signed overflow of a+b during the run
//   step_cnt       c updates completed in the current/last run
//   bus            master side of the data bus
// Each context is {a,b,c,k} at base + i*STRIDE; per context while(--k >= 0) {c=a+b; a=b; b=c;}.
module fibonacci_mc #(
  parameter int XLEN   = 32,
  parameter int AW     = 32,
  parameter int NCTX   = 4,
  parameter int STRIDE = 16,
  parameter int SAT    = 0
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            start,
  input  logic [AW-1:0]   base,
  input  logic [NCTX-1:0] ctx_mask,
  output logic            idle,
  output logic            done,
  output logic [3:0]      cur_ctx,
  output logic            ovf,
  output logic [31:0]     step_cnt,
  fibonacci_mc_if.master  bus
);
  localparam int W = XLEN / 8;
  typedef enum logic [3:0] {IDLE, SCAN, RD_K, WR_K, RD_A, RD_B, WR_C, WR_A, WR_B, FIN} state_t;
  state_t state, nxt;
  logic req, go, xfer, is_bus, ov;
  logic [AW-1:0] base_r, ctx_addr, off;
  logic [NCTX-1:0] pend;
  logic [3:0] low;
  logic [XLEN-1:0] k_r, a_r, b_r, km1, sum, c_val;
  assign go   = idle && start;
  assign xfer = req && bus.ready;
  assign km1  = k_r - XLEN'(1);
  assign sum  = a_r + b_r;
  assign ov   = (a_r[XLEN-1] == b_r[XLEN-1]) && (sum[XLEN-1] != a_r[XLEN-1]);
  assign c_val = (SAT != 0 && ov) ? (a_r[XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}}) : sum;
  // pend holds the contexts still to visit; the lowest set bit is the next one
  always_comb begin
    low = '0;
    for (int i = NCTX - 1; i >= 0; i--) if (pend[i]) low = 4'(i);
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, FIN: nxt = go ? SCAN : IDLE;
      SCAN: nxt = (pend == '0) ? FIN : RD_K;
      RD_K: nxt = xfer ? WR_K : state;
      WR_K: nxt = xfer ? (km1[XLEN-1] ? SCAN : RD_A) : state;
      RD_A: nxt = xfer ? RD_B : state;
      RD_B: nxt = xfer ? WR_C : state;
      WR_C: nxt = xfer ? WR_A : state;
      WR_A: nxt = xfer ? WR_B : state;
      WR_B: nxt = xfer ? RD_K : state;
      default: nxt = IDLE;
    endcase
  end
  // req drops on the completing cycle, so each bus state idles one cycle before requesting
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req <= 1'b0;
      base_r <= '0;
      pend <= '0;
      ctx_addr <= '0;
      cur_ctx <= '0;
      k_r <= '0;
      a_r <= '0;
      b_r <= '0;
      ovf <= 1'b0;
      step_cnt <= '0;
    end else begin
      req <= req ? !bus.ready : is_bus;
      if (go) begin
        base_r <= base;
        pend <= ctx_mask;
        ovf <= 1'b0;
        step_cnt <= '0;
      end
      if (state == SCAN && pend != '0) begin
        cur_ctx <= low;
        pend <= pend & ~(NCTX'(1) << low);
        ctx_addr <= base_r + AW'(low) * AW'(STRIDE);
      end
      if (xfer && state == RD_K) k_r <= bus.rdata;
      if (xfer && state == RD_A) a_r <= bus.rdata;
      if (xfer && state == RD_B) b_r <= bus.rdata;
      if (xfer && state == WR_C) begin
        step_cnt <= step_cnt + 32'd1;
        if (ov) ovf <= 1'b1;
      end
    end
  end
  // a_r/b_r stay put through WR_C..WR_B, so c_val is still the written c during WR_B
  always_comb begin
    is_bus = state inside {RD_K, WR_K, RD_A, RD_B, WR_C, WR_A, WR_B};
    idle = state == IDLE || state == FIN;
    done = state == FIN;
    off = (state == RD_K || state == WR_K) ? AW'(3 * W) :
          (state == RD_B || state == WR_B) ? AW'(W) :
          (state == WR_C) ? AW'(2 * W) : '0;
    bus.valid = req;
    bus.size = 3'($clog2(W));
    bus.write = state inside {WR_K, WR_C, WR_A, WR_B};
    bus.addr = is_bus ? ctx_addr + off : '0;
    bus.wdata = (state == WR_K) ? km1 :
                (state == WR_C || state == WR_B) ? c_val :
                (state == WR_A) ? b_r : '0;
  end
endmodule

// File: tb/tb_fibonacci_mc.sv
// tb_fibonacci_mc: scoreboard bench; stimulus queues expected bus transactions, monitors check them.
module tb_fibonacci_mc;
  logic clk = 1'b0, rstb = 1'b0, start = 1'b0, start1 = 1'b0;
  logic [31:0] base = '0;
  logic [3:0] ctx_mask = '0;
  logic idle, done, ovf, idle1, done1, ovf1;
  logic [3:0] cur_ctx, cur_ctx1;
  logic [31:0] step_cnt, step_cnt1;
  fibonacci_mc_if #(.XLEN(32), .AW(32)) bif();
  fibonacci_mc_if #(.XLEN(32), .AW(32)) bif1();
  fibonacci_mc #(.XLEN(32), .AW(32), .NCTX(4), .STRIDE(16), .SAT(0)) dut (
    .clk(clk), .rstb(rstb), .start(start), .base(base), .ctx_mask(ctx_mask),
    .idle(idle), .done(done), .cur_ctx(cur_ctx), .ovf(ovf), .step_cnt(step_cnt), .bus(bif.master));
  fibonacci_mc #(.XLEN(32), .AW(32), .NCTX(1), .STRIDE(16), .SAT(1)) dut1 (
    .clk(clk), .rstb(rstb), .start(start1), .base(32'h0), .ctx_mask(1'b1),
    .idle(idle1), .done(done1), .cur_ctx(cur_ctx1), .ovf(ovf1), .step_cnt(step_cnt1), .bus(bif1.master));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] data; logic [3:0] ctx;} txn_t;
  txn_t q0[$], q1[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mem1 [4];
  int total = 0, bad = 0, wait_cyc = 0, txn0 = 0, done_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic push(input bit which, input logic [31:0] addr, input bit wr, input logic [31:0] data, input logic [3:0] ctx);
    txn_t t;
    t = '{addr, wr, data, ctx};
    if (which) q1.push_back(t);
    else q0.push_back(t);
  endtask
  task automatic gen(input bit which, input logic [31:0] ba, input logic [3:0] ctx,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] k, input bit sat);
    logic [31:0] s, c;
    bit o;
    while (1) begin
      push(which, ba + 12, 0, 0, ctx);
      k = k - 1;
      push(which, ba + 12, 1, k, ctx);
      if (k[31]) break;
      push(which, ba, 0, 0, ctx);
      push(which, ba + 4, 0, 0, ctx);
      s = a + b;
      o = (a[31] == b[31]) && (s[31] != a[31]);
      c = (sat && o) ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s;
      push(which, ba + 8, 1, c, ctx);
      push(which, ba, 1, b, ctx);
      push(which, ba + 4, 1, c, ctx);
      a = b;
      b = c;
    end
  endtask
  task automatic put(input logic [31:0] ba, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] k);
    mem[ba] = a;
    mem[ba + 4] = b;
    mem[ba + 8] = c;
    mem[ba + 12] = k;
  endtask
  task automatic run0(input logic [31:0] b, input logic [3:0] m, output int cyc);
    @(negedge clk);
    base = b;
    ctx_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = 32'hDEAD_0000;
    ctx_mask = 4'hF;
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", cyc);
    end
  endtask
  task automatic post0(input int d0);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("idle_after", 32'(idle), 1);
    chk("queue_empty", 32'(q0.size()), 0);
  endtask
  initial begin
    int wc;
    wc = 0;
    bif.ready = 1'b0;
    bif.rdata = '0;
    forever begin
      @(negedge clk);
      if (!bif.valid) begin
        bif.ready = 1'b0;
        wc = 0;
      end else if (wc >= wait_cyc) begin
        bif.ready = 1'b1;
        bif.rdata = mem.exists(bif.addr) ? mem[bif.addr] : 32'h0;
        if (bif.write) mem[bif.addr] = bif.wdata;
      end else begin
        bif.ready = 1'b0;
        wc++;
      end
    end
  end
  initial begin
    bif1.ready = 1'b0;
    bif1.rdata = '0;
    forever begin
      @(negedge clk);
      bif1.ready = bif1.valid;
      if (bif1.valid) begin
        bif1.rdata = mem1[bif1.addr[3:2]];
        if (bif1.write) mem1[bif1.addr[3:2]] = bif1.wdata;
      end
    end
  end
  // every cycle valid is high, addr/write/wdata must already match the pending transaction
  initial forever begin
    @(negedge clk);
    #1;
    if (done) done_cnt++;
    if (bif.valid) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_txn: got addr %h write %0d want no transaction", bif.addr, bif.write);
      end else begin
        chk("addr", bif.addr, q0[0].addr);
        chk("write", 32'(bif.write), 32'(q0[0].wr));
        if (q0[0].wr) chk("wdata", bif.wdata, q0[0].data);
        chk("cur_ctx", 32'(cur_ctx), 32'(q0[0].ctx));
        if (bif.ready) void'(q0.pop_front());
      end
      if (bif.ready) txn0++;
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (bif1.valid && bif1.ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_txn1: got addr %h want no transaction", bif1.addr);
      end else begin
        chk("addr1", bif1.addr, q1[0].addr);
        chk("write1", 32'(bif1.write), 32'(q1[0].wr));
        if (q1[0].wr) chk("wdata1", bif1.wdata, q1[0].data);
        void'(q1.pop_front());
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc, d0, t0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(bif.valid), 0);
    chk("rst_write", 32'(bif.write), 0);
    chk("rst_addr", bif.addr, 0);
    chk("rst_wdata", bif.wdata, 0);
    chk("rst_cur_ctx", 32'(cur_ctx), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_size", 32'(bif.size), 2);
    @(negedge clk);
    rstb = 1'b1;
    put(32'h0, 0, 1, 0, 5);
    gen(0, 32'h0, 0, 0, 1, 5, 0);
    d0 = done_cnt; t0 = txn0;
    run0(32'h0, 4'b0001, cyc);
    post0(d0);
    chk("t1_txns", 32'(txn0 - t0), 37);
    chk("t1_a", mem[32'h0], 5);
    chk("t1_b", mem[32'h4], 8);
    chk("t1_c", mem[32'h8], 8);
    chk("t1_k", mem[32'hC], 32'hFFFF_FFFF);
    chk("t1_step", step_cnt, 5);
    chk("t1_ovf", 32'(ovf), 0);
    put(32'h40, 3, 4, 9, 0);
    gen(0, 32'h40, 0, 3, 4, 0, 0);
    d0 = done_cnt; t0 = txn0;
    run0(32'h40, 4'b0001, cyc);
    post0(d0);
    chk("t2_txns", 32'(txn0 - t0), 2);
    chk("t2_a", mem[32'h40], 3);
    chk("t2_b", mem[32'h44], 4);
    chk("t2_c", mem[32'h48], 9);
    chk("t2_k", mem[32'h4C], 32'hFFFF_FFFF);
    chk("t2_step", step_cnt, 0);
    put(32'h80, 32'h7FFF_FFFF, 1, 0, 1);
    gen(0, 32'h80, 0, 32'h7FFF_FFFF, 1, 1, 0);
    d0 = done_cnt;
    run0(32'h80, 4'b0001, cyc);
    post0(d0);
    chk("t3_c_wrap", mem[32'h88], 32'h8000_0000);
    chk("t3_b_wrap", mem[32'h84], 32'h8000_0000);
    chk("t3_a_wrap", mem[32'h80], 1);
    chk("t3_ovf_wrap", 32'(ovf), 1);
    chk("t3_step", step_cnt, 1);
    mem1 = '{32'h7FFF_FFFF, 32'h1, 32'h0, 32'h1};
    gen(1, 32'h0, 0, 32'h7FFF_FFFF, 1, 1, 1);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("t3_done1", 32'(done1), 1);
    chk("t3_c_sat", mem1[2], 32'h7FFF_FFFF);
    chk("t3_b_sat", mem1[1], 32'h7FFF_FFFF);
    chk("t3_ovf_sat", 32'(ovf1), 1);
    chk("t3_q1_empty", 32'(q1.size()), 0);
    put(32'h100, 11, 22, 33, 3);
    put(32'h110, 1, 2, 0, 1);
    put(32'h120, 44, 55, 66, 3);
    put(32'h130, 2, 3, 0, 2);
    gen(0, 32'h110, 1, 1, 2, 1, 0);
    gen(0, 32'h130, 3, 2, 3, 2, 0);
    d0 = done_cnt;
    run0(32'h100, 4'b1010, cyc);
    post0(d0);
    chk("t4_c1", mem[32'h118], 3);
    chk("t4_b3", mem[32'h134], 8);
    chk("t4_k0_untouched", mem[32'h10C], 3);
    chk("t4_k2_untouched", mem[32'h12C], 3);
    chk("t4_step", step_cnt, 3);
    chk("t4_ovf_cleared", 32'(ovf), 0);
    chk("t4_last_ctx", 32'(cur_ctx), 3);
    d0 = done_cnt; t0 = txn0;
    run0(32'h500, 4'b0000, cyc);
    chk("mask0_latency", 32'(cyc), 2);
    post0(d0);
    chk("mask0_txns", 32'(txn0 - t0), 0);
    wait_cyc = 3;
    put(32'h200, 0, 1, 0, 5);
    gen(0, 32'h200, 0, 0, 1, 5, 0);
    d0 = done_cnt;
    run0(32'h200, 4'b0001, cyc);
    post0(d0);
    chk("t5_a", mem[32'h200], 5);
    chk("t5_b", mem[32'h204], 8);
    chk("t5_c", mem[32'h208], 8);
    chk("t5_k", mem[32'h20C], 32'hFFFF_FFFF);
    wait_cyc = 0;
    put(32'h300, 0, 1, 0, 5);
    gen(0, 32'h300, 0, 0, 1, 5, 0);
    @(negedge clk);
    base = 32'h300;
    ctx_mask = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(bif.valid && bif.write && bif.addr == 32'h308) && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("t6_reached_wr_c", 32'(bif.valid && bif.write && bif.addr == 32'h308), 1);
    rstb = 1'b0;
    #1;
    q0.delete();
    chk("t6_valid", 32'(bif.valid), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_done", 32'(done), 0);
    chk("t6_write", 32'(bif.write), 0);
    chk("t6_addr", bif.addr, 0);
    chk("t6_wdata", bif.wdata, 0);
    chk("t6_cur_ctx", 32'(cur_ctx), 0);
    chk("t6_ovf", 32'(ovf), 0);
    chk("t6_step", step_cnt, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    put(32'h300, 0, 1, 0, 2);
    gen(0, 32'h300, 0, 0, 1, 2, 0);
    d0 = done_cnt;
    run0(32'h300, 4'b0001, cyc);
    post0(d0);
    chk("t6_rerun_b", mem[32'h304], 2);
    chk("t6_rerun_step", step_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
